// File: rtl/alu_execute_stage_if.sv
// Handshake bundle between the ALU operand mux, the execute stage
// and the writeback consumer.
interface alu_execute_stage_if #(
   parameter int DATA_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        alu_operation;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic              shifter_carry;
   logic              set_flags;
   logic [3:0]        rd_in;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] result;
   logic [3:0]        rd_out;
   logic              rd_we;

   modport master (
      output in_valid, alu_operation, op_a, op_b,
      output shifter_carry, set_flags, rd_in, out_ready,
      input  in_ready, out_valid, result, rd_out, rd_we
   );

   modport slave (
      input  in_valid, alu_operation, op_a, op_b,
      input  shifter_carry, set_flags, rd_in, out_ready,
      output in_ready, out_valid, result, rd_out, rd_we
   );
endinterface

// File: rtl/alu_execute_stage.sv
// ARMv4 ALU execute stage: one-entry result register plus NZCV flags.
// Define ALU_FLAG_FWD_EN to forward held S-op flags instead of stalling.
module alu_execute_stage #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   alu_execute_stage_if.slave bus,
   output logic [3:0]        flags_q
);
   localparam int W = DATA_W;

   logic          valid_q;
   logic [W-1:0]  res_q;
   logic [3:0]    rd_q;
   logic          we_q;
   logic [3:0]    pend_q;
   logic          held_s_q;

   logic          eff_c;
   logic          eff_v;
   logic          stall;
   logic          accept;
   logic          drain;

   logic [W-1:0]  x;
   logic [W-1:0]  y;
   logic          cin;
   logic          arith;
   logic [W-1:0]  lres;
   logic [W:0]    sum;
   logic [W-1:0]  res_d;
   logic          c_d;
   logic          v_d;
   logic [3:0]    nzcv_d;
   logic          we_d;
   logic          uses_c;

   assign uses_c = (bus.alu_operation == 4'h5) |
                   (bus.alu_operation == 4'h6) |
                   (bus.alu_operation == 4'h7);

`ifdef ALU_FLAG_FWD_EN
   logic fwd;
   assign fwd   = valid_q & held_s_q;
   assign eff_c = fwd ? pend_q[1] : flags_q[1];
   assign eff_v = fwd ? pend_q[0] : flags_q[0];
   assign stall = 1'b0;
   logic unused_fwd;
   assign unused_fwd = uses_c;
`else
   assign eff_c = flags_q[1];
   assign eff_v = flags_q[0];
   // Flags are not visible until commit, so dependents wait one bubble.
   assign stall = valid_q & held_s_q & (bus.set_flags | uses_c);
`endif

   assign bus.in_ready  = (!valid_q | bus.out_ready) & !stall;
   assign accept        = bus.in_valid & bus.in_ready;
   assign drain         = valid_q & bus.out_ready;

   assign bus.out_valid = valid_q;
   assign bus.result    = res_q;
   assign bus.rd_out    = rd_q;
   assign bus.rd_we     = we_q;

   always_comb begin
      x     = '0;
      y     = '0;
      cin   = 1'b0;
      arith = 1'b1;
      lres  = '0;
      unique case (bus.alu_operation)
         4'h0, 4'h8: begin
            arith = 1'b0;
            lres  = bus.op_a & bus.op_b;
         end
         4'h1, 4'h9: begin
            arith = 1'b0;
            lres  = bus.op_a ^ bus.op_b;
         end
         4'h2, 4'hA: begin
            x   = bus.op_a;
            y   = ~bus.op_b;
            cin = 1'b1;
         end
         4'h3: begin
            x   = bus.op_b;
            y   = ~bus.op_a;
            cin = 1'b1;
         end
         4'h4, 4'hB: begin
            x = bus.op_a;
            y = bus.op_b;
         end
         4'h5: begin
            x   = bus.op_a;
            y   = bus.op_b;
            cin = eff_c;
         end
         4'h6: begin
            x   = bus.op_a;
            y   = ~bus.op_b;
            cin = eff_c;
         end
         4'h7: begin
            x   = bus.op_b;
            y   = ~bus.op_a;
            cin = eff_c;
         end
         4'hC: begin
            arith = 1'b0;
            lres  = bus.op_a | bus.op_b;
         end
         4'hD: begin
            arith = 1'b0;
            lres  = bus.op_b;
         end
         4'hE: begin
            arith = 1'b0;
            lres  = bus.op_a & ~bus.op_b;
         end
         4'hF: begin
            arith = 1'b0;
            lres  = ~bus.op_b;
         end
      endcase

      sum   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
      res_d = arith ? sum[W-1:0] : lres;
      c_d   = arith ? sum[W] : bus.shifter_carry;
      // Overflow: like-signed addends giving a differently-signed sum.
      v_d   = arith ? ((x[W-1] == y[W-1]) & (sum[W-1] != x[W-1]))
                    : eff_v;
      nzcv_d = {res_d[W-1], res_d == '0, c_d, v_d};
      we_d   = bus.alu_operation[3:2] != 2'b10;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q  <= 1'b0;
         res_q    <= '0;
         rd_q     <= '0;
         we_q     <= 1'b0;
         pend_q   <= '0;
         held_s_q <= 1'b0;
         flags_q  <= '0;
      end else begin
         if (drain & held_s_q)
            flags_q <= pend_q;
         if (accept) begin
            valid_q  <= 1'b1;
            res_q    <= res_d;
            rd_q     <= bus.rd_in;
            we_q     <= we_d;
            pend_q   <= nzcv_d;
            held_s_q <= bus.set_flags;
         end else if (drain) begin
            valid_q  <= 1'b0;
         end
      end
   end
endmodule

// File: doc/alu_execute_stage.md
Name: alu_execute_stage

Overview:
- Registered ARMv4 ALU execute stage, directly downstream of the ALU operation mux.
- Consumes the selected 4-bit ARM data-processing opcode plus shifted operands and produces a registered result and destination tag.
- Owns the NZCV flag register.
- Uses a one-entry valid/ready output register so the datapath can stall writeback without losing a result.

Parameters:
- DATA_W, 32, operand/result width; flags taken from bit DATA_W-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  operation presented.
- in_ready  out  1  stage can accept this cycle.
- alu_operation  in  4  ARM opcode: 0 AND, 1 EOR, 2 SUB, 3 RSB, 4 ADD, 5 ADC, 6 SBC, 7 RSC, 8 TST, 9 TEQ, A CMP, B CMN, C ORR, D MOV, E BIC, F MVN.
- op_a  in  DATA_W  Rn value.
- op_b  in  DATA_W  shifter operand.
- shifter_carry  in  1  shifter carry-out, used as C for logical ops.
- set_flags  in  1  S bit.
- rd_in  in  4  destination register index.
- out_valid  out  1  output register holds a result.
- out_ready  in  1  consumer takes result.
- result  out  DATA_W  registered ALU result.
- rd_out  out  4  registered destination index.
- rd_we  out  1  result to be written (0 for TST/TEQ/CMP/CMN).
- flags_q  out  4  committed NZCV, N=bit3, V=bit0.

Behaviour:
- Reset (async, rst=1): out_valid=0, result=0, rd_out=0, rd_we=0, flags_q=0, pending S state cleared. Reset mid-operation discards the held result; nothing commits.
- Accept: in_valid & in_ready at a clk edge. The result is computed combinationally and loaded into the output register. Latency is 1 cycle: out_valid rises the edge after accept.
- Output register empty-or-draining: in_ready = (!out_valid | out_ready) & !stall. Accept and drain in the same cycle are allowed, giving back-to-back throughput of 1 per cycle.
- Arithmetic is computed on DATA_W+1 bits.
  - SUB = a + ~b + 1; RSB = b + ~a + 1.
  - ADC adds C; SBC = a + ~b + C; RSC = b + ~a + C.
  - CMP as SUB; CMN as ADD; TST as AND; TEQ as EOR.
  - MOV = b; MVN = ~b; BIC = a & ~b.
- Flag computation (the pending NZCV value held with the result):
  - N = result[DATA_W-1]; Z = (result == 0).
  - Arithmetic ops: C = carry-out (for subtract forms, C = NOT borrow). V = signed overflow of the actual operand pair.
  - Logical ops: C = shifter_carry; V is unchanged from effective flags.
- Carry-in C and the unchanged V come from the effective flags (see Optional Feature).
- Flags commit: flags_q <= pending NZCV on the edge where out_valid & out_ready and the held op had set_flags=1. Ops with set_flags=0 never alter flags_q.
- Result overflow wraps modulo 2^DATA_W.
- While out_valid & !out_ready, result, rd_out, rd_we and the pending flags hold stable. A result is never dropped or duplicated.
- in_valid without accept: inputs are ignored; there is no side effect.

Optional Feature:
- Macro: ALU_FLAG_FWD_EN.
- Defined: the effective flags are the pending NZCV of the held op when out_valid & held set_flags=1, otherwise flags_q. stall=0 always, so dependent ops (ADC/SBC/RSC, or any S op) proceed back-to-back.
- Undefined: the effective flags are always flags_q. stall=1 when out_valid & held set_flags=1 & the incoming op has (set_flags=1 or opcode in {5,6,7}). This holds regardless of out_ready and costs exactly one bubble after commit.

Test Plan:
- Reset → all outputs 0, in_ready=1. Then ADD a=5, b=7, S=0 → next cycle out_valid=1, result=12, rd_we=1, flags_q=0000 unchanged.
- SUB S=1, a=3, b=3 → result=0. On drain flags_q=0110 (Z=1, C=1). CMP a=0x80000000, b=1 → rd_we=0, on drain flags_q=0011 (C=1, V=1).
- ADDS a=0xFFFFFFFF, b=1 then ADC a=0, b=0:
  - Second result=1 in both builds.
  - With ALU_FLAG_FWD_EN: no bubble.
  - Without: in_ready=0 for one cycle while the ADDS is held.
- out_ready=0 for 3 cycles holding MOV b=0xDEADBEEF → result stable, in_ready=0, a second op is not accepted. out_ready=1 → drains, and the next op is accepted the same edge.
- ANDS a=0xF0, b=0x0F, shifter_carry=1, prior V=1 → result=0, flags_q=0111 (V preserved, C from shifter).
- Assert rst while out_valid=1 with a pending S op → out_valid=0 immediately, flags_q=0, the pending flags are never committed.
